knight_rider_scanner: RTL



---
 rtl/knight_rider_pkg.sv | 16 +
 rtl/kr_trail_mask.sv | 30 +++
 rtl/knight_rider_scanner.sv | 130 +++++++++++++
 3 files changed

// File: rtl/knight_rider_pkg.sv
// Shared types and constants for the Knight Rider flasher blocks.
package knight_rider_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown,
    StDwell
  } kr_state_e;

  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;

  localparam int unsigned KrDefaultLeds = 10;

endpackage

// File: rtl/kr_trail_mask.sv
// Combinational head-plus-trail LED mask; trail bits that fall off either end are dropped.
module kr_trail_mask
  import knight_rider_pkg::*;
#(
  parameter int unsigned N    = KrDefaultLeds,
  parameter int unsigned TAIL = 2
) (
  input  logic [$clog2(N)-1:0] pos_i,
  input  logic                 dir_i,
  output logic [N-1:0]         mask_o
);

  int p;
  assign p = int'(pos_i);

  // Trail sits behind the head: below it when moving up, above it when moving down.
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (i == p) begin
        mask_o[i] = 1'b1;
      end else if (dir_i == DirUp) begin
        mask_o[i] = (i < p) && ((p - i) <= int'(TAIL));
      end else begin
        mask_o[i] = (i > p) && ((i - p) <= int'(TAIL));
      end
    end
  end

endmodule

// File: rtl/knight_rider_scanner.sv
// Bouncing-head LED scanner with optional trail and end dwell, stepped by TICK while ENABLE.
module knight_rider_scanner
  import knight_rider_pkg::*;
#(
  parameter int unsigned N           = KrDefaultLeds,
  parameter int unsigned TAIL        = 2,
  parameter int unsigned PAUSE_TICKS = 0
) (
  input  logic                 CLK,
  input  logic                 CLEAR,
  input  logic                 TICK,
  input  logic                 ENABLE,
  output logic [N-1:0]         LEDR,
  output logic [$clog2(N)-1:0] POS,
  output logic                 DIR,
  output logic                 END_HIT
);

  localparam int unsigned PW       = $clog2(N);
  localparam logic [PW-1:0] PosMax = PW'(N - 1);
  localparam logic [PW-1:0] PosOne = PW'(1);
  localparam logic [7:0] PauseCnt  = 8'(PAUSE_TICKS);
  localparam logic HasPause        = (PAUSE_TICKS != 0);

  kr_state_e     state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          dir_q, dir_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [N-1:0]  led_q, led_d;
  logic          end_hit_q, end_hit_d;
  logic [N-1:0]  mask;
  logic          advance;

  assign advance = ENABLE & TICK;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ENABLE) state_d = StUp;
      end
      StUp: begin
        if (advance) begin
          if (pos_q != PosMax) begin
            pos_d = pos_q + PosOne;
          end else if (HasPause) begin
            state_d = StDwell;
            cnt_d   = 8'd1;
          end else begin
            dir_d   = DirDown;
            pos_d   = pos_q - PosOne;
            state_d = StDown;
          end
        end
      end
      StDown: begin
        if (advance) begin
          if (pos_q != '0) begin
            pos_d = pos_q - PosOne;
          end else if (HasPause) begin
            state_d = StDwell;
            cnt_d   = 8'd1;
          end else begin
            dir_d   = DirUp;
            pos_d   = pos_q + PosOne;
            state_d = StUp;
          end
        end
      end
      StDwell: begin
        if (advance) begin
          if (cnt_q == PauseCnt) begin
            cnt_d = 8'd0;
            dir_d = ~dir_q;
            // dir_q still holds the pre-reversal direction, i.e. which end we sit at.
            if (dir_q == DirUp) begin
              pos_d   = pos_q - PosOne;
              state_d = StDown;
            end else begin
              pos_d   = pos_q + PosOne;
              state_d = StUp;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    end_hit_d = advance && (pos_d != pos_q) && ((pos_d == '0) || (pos_d == PosMax));
    led_d     = (ENABLE && (state_d != StIdle)) ? mask : '0;
  end

  kr_trail_mask #(
    .N    (N),
    .TAIL (TAIL)
  ) u_trail_mask (
    .pos_i  (pos_d),
    .dir_i  (dir_d),
    .mask_o (mask)
  );

  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q   <= StIdle;
      pos_q     <= '0;
      dir_q     <= DirUp;
      cnt_q     <= 8'd0;
      led_q     <= '0;
      end_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      end_hit_q <= end_hit_d;
    end
  end

  assign LEDR    = led_q;
  assign POS     = pos_q;
  assign DIR     = dir_q;
  assign END_HIT = end_hit_q;

endmodule
